// File: rtl/mvau_defn.sv
// rtl/mvau_defn.sv - shared types and width helpers for the MVAU activation feeder
package mvau_defn;

    typedef enum logic {
        FILL  = 1'b0,
        REUSE = 1'b1
    } feed_state_e;

    function automatic int calc_ti(input int tsrci, input int simd);
        return tsrci * simd;
    endfunction

    // Weight address must span SF*NF entries, never narrower than one bit.
    function automatic int calc_wa(input int sf, input int nf);
        return (sf * nf > 1) ? $clog2(sf * nf) : 1;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int TI_DEFAULT = calc_ti(4, 2);
    localparam int WA_DEFAULT = calc_wa(4, 3);

endpackage

// File: rtl/mvau_feed_buf.sv
// rtl/mvau_feed_buf.sv - SF-deep activation buffer, one write port, async read port
module mvau_feed_buf
    import mvau_defn::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int AW   = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // No reset: entries are always rewritten during FILL before REUSE reads them.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mvau_stream_feed.sv
// rtl/mvau_stream_feed.sv - activation feeder replaying each input vector NF times
module mvau_stream_feed
    import mvau_defn::*;
#(
    parameter int SIMD  = 2,
    parameter int TSrcI = 4,
    parameter int SF    = 4,
    parameter int NF    = 3,
    localparam int TI   = calc_ti(TSrcI, SIMD),
    localparam int WA   = calc_wa(SF, NF)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_v,
    input  logic [TI-1:0] in_act,
    output logic          in_rdy,
    input  logic          out_rdy,
    output logic [TI-1:0] out_act,
    output logic          do_mvau_stream,
    output logic          sf_clr,
    output logic          nf_clr,
    output logic [WA-1:0] wgt_addr
);

    localparam int SW = cnt_w(SF);
    localparam int NW = cnt_w(NF);

    feed_state_e    state_q, state_d;
    logic [SW-1:0]  sf_q;
    logic [NW-1:0]  nf_q;
    logic           issue;
    logic           sf_last;
    logic           nf_last;
    logic [TI-1:0]  buf_rdata;
    logic [WA-1:0]  beat_addr;

    assign sf_last   = (sf_q == SW'(SF - 1));
    assign nf_last   = (nf_q == NW'(NF - 1));
    assign beat_addr = WA'(nf_q) * WA'(SF) + WA'(sf_q);

    always_comb begin
        state_d = state_q;
        in_rdy  = 1'b0;
        issue   = 1'b0;
        case (state_q)
            FILL: begin
                in_rdy = out_rdy;
                issue  = in_v & out_rdy;
            end
            REUSE: begin
                issue = out_rdy;
            end
            default: state_d = FILL;
        endcase
        // With NF==1 nf_last is constant, so the FSM never leaves FILL.
        if (issue && sf_last) begin
            state_d = nf_last ? FILL : REUSE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sf_q           <= '0;
            nf_q           <= '0;
            do_mvau_stream <= 1'b0;
            sf_clr         <= 1'b0;
            nf_clr         <= 1'b0;
            out_act        <= '0;
            wgt_addr       <= '0;
        end else begin
            do_mvau_stream <= issue;
            sf_clr         <= issue & sf_last;
            nf_clr         <= issue & sf_last & nf_last;
            if (issue) begin
                out_act  <= (state_q == FILL) ? in_act : buf_rdata;
                wgt_addr <= beat_addr;
                sf_q     <= sf_last ? '0 : sf_q + 1'b1;
                if (sf_last) begin
                    nf_q <= nf_last ? '0 : nf_q + 1'b1;
                end
            end
        end
    end

    mvau_feed_buf #(
        .DEPTH (SF),
        .WIDTH (TI)
    ) u_buf (
        .clk   (clk),
        .we    (issue && (state_q == FILL) && (NF > 1)),
        .waddr (sf_q),
        .wdata (in_act),
        .raddr (sf_q),
        .rdata (buf_rdata)
    );

endmodule

// File: tb/tb_mvau_stream_feed.sv
// tb/tb_mvau_stream_feed.sv - scoreboard bench over three SF/NF configurations
module tb_mvau_stream_feed;

    localparam int N = 3;

    function automatic int sf_of(input int g);
        return (g == 2) ? 1 : 4;
    endfunction

    function automatic int nf_of(input int g);
        case (g)
            0:       return 3;
            1:       return 1;
            default: return 2;
        endcase
    endfunction

    typedef struct {
        logic [7:0] data;
        int         wgt;
        logic       sfc;
        logic       nfc;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   in_v;
    logic [N-1:0]   out_rdy;
    logic [N*8-1:0] in_act_f;
    logic [N-1:0]   in_rdy;
    logic [N-1:0]   do_v;
    logic [N-1:0]   sfc_v;
    logic [N-1:0]   nfc_v;
    logic [N*8-1:0] out_act_f;
    logic [N*4-1:0] wa_f;

    beat_t      exp_q [N][$];
    int         bcnt [N];
    logic [7:0] grp [N][4];
    int         checks = 0;
    int         passes = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int GSF = sf_of(g);
        localparam int GNF = nf_of(g);
        localparam int GWA = mvau_defn::calc_wa(GSF, GNF);
        logic [GWA-1:0] wa;
        logic [7:0]     oa;
        mvau_stream_feed #(
            .SIMD (2),
            .TSrcI(4),
            .SF   (GSF),
            .NF   (GNF)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .in_v          (in_v[g]),
            .in_act        (in_act_f[g*8 +: 8]),
            .in_rdy        (in_rdy[g]),
            .out_rdy       (out_rdy[g]),
            .out_act       (oa),
            .do_mvau_stream(do_v[g]),
            .sf_clr        (sfc_v[g]),
            .nf_clr        (nfc_v[g]),
            .wgt_addr      (wa)
        );
        assign out_act_f[g*8 +: 8] = oa;
        assign wa_f[g*4 +: 4]      = 4'(wa);
    end

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s dut%0d got %0h want %0h at %0t", name, g, act, exp, $time);
        end
    endtask

    task automatic chk_reset_state();
        for (int g = 0; g < N; g++) begin
            chk("rst_do", g, 32'(do_v[g]), 0);
            chk("rst_sfc", g, 32'(sfc_v[g]), 0);
            chk("rst_nfc", g, 32'(nfc_v[g]), 0);
            chk("rst_act", g, 32'(out_act_f[g*8 +: 8]), 0);
            chk("rst_wgt", g, 32'(wa_f[g*4 +: 4]), 0);
        end
    endtask

    // Monitor: every issued beat must appear exactly one cycle later, in order.
    initial begin
        beat_t e;
        forever begin
            @(posedge clk);
            #2;
            for (int g = 0; g < N; g++) begin
                if (do_v[g]) begin
                    if (exp_q[g].size() == 0) begin
                        chk("spurious_beat", g, 1, 0);
                    end else begin
                        e = exp_q[g].pop_front();
                        chk("out_act", g, 32'(out_act_f[g*8 +: 8]), 32'(e.data));
                        chk("wgt_addr", g, 32'(wa_f[g*4 +: 4]), 32'(e.wgt));
                        chk("sf_clr", g, 32'(sfc_v[g]), 32'(e.sfc));
                        chk("nf_clr", g, 32'(nfc_v[g]), 32'(e.nfc));
                    end
                end else begin
                    if (exp_q[g].size() != 0) begin
                        chk("missing_beat", g, 0, 1);
                        exp_q[g].delete();
                    end
                    if (sfc_v[g] || nfc_v[g]) begin
                        chk("idle_clr", g, 32'({sfc_v[g], nfc_v[g]}), 0);
                    end
                end
            end
        end
    end

    initial begin
        logic v, r, fill, iss;
        int   c, s, p, sf, nf;
        bit   just_reset;
        beat_t e;

        rst      = 1'b1;
        in_v     = '0;
        out_rdy  = '0;
        in_act_f = '0;
        for (int g = 0; g < N; g++) bcnt[g] = 0;
        repeat (3) @(negedge clk);
        chk_reset_state();
        rst = 1'b0;
        just_reset = 1'b0;

        for (int phase = 0; phase < 4; phase++) begin
            for (int cyc = 0; cyc < 250; cyc++) begin
                @(negedge clk);
                if (just_reset) begin
                    chk_reset_state();
                    rst = 1'b0;
                    just_reset = 1'b0;
                end
                if (phase >= 1 && cyc == 137) begin
                    rst     = 1'b1;
                    in_v    = '0;
                    out_rdy = '0;
                    for (int g = 0; g < N; g++) bcnt[g] = 0;
                    just_reset = 1'b1;
                    continue;
                end
                for (int g = 0; g < N; g++) begin
                    case (phase)
                        0: begin v = 1'b1; r = 1'b1; end
                        1: begin v = 1'($urandom % 2); r = (($urandom % 4) != 0); end
                        2: begin v = 1'(cyc % 2); r = 1'b1; end
                        default: begin v = (($urandom % 4) != 0); r = ((cyc % 8) < 5); end
                    endcase
                    in_v[g]             = v;
                    out_rdy[g]          = r;
                    in_act_f[g*8 +: 8]  = 8'($urandom);
                end
                #1;
                for (int g = 0; g < N; g++) begin
                    sf   = sf_of(g);
                    nf   = nf_of(g);
                    c    = bcnt[g] % (sf * nf);
                    p    = c / sf;
                    s    = c % sf;
                    fill = (c < sf);
                    chk("in_rdy", g, 32'(in_rdy[g]), fill ? 32'(out_rdy[g]) : 0);
                    iss = fill ? (in_v[g] & out_rdy[g]) : out_rdy[g];
                    if (iss) begin
                        if (fill) grp[g][s] = in_act_f[g*8 +: 8];
                        e.data = grp[g][s];
                        e.wgt  = p * sf + s;
                        e.sfc  = (s == sf - 1);
                        e.nfc  = (c == sf * nf - 1);
                        exp_q[g].push_back(e);
                        bcnt[g]++;
                    end
                end
            end
        end

        @(negedge clk);
        in_v    = '0;
        out_rdy = '0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < N; g++) begin
            chk("drain", g, 32'(exp_q[g].size()), 0);
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mvau_stream_feed.md
MVAU_STREAM_FEED -- requirements
Module: mvau_stream_feed

Interface
REQ-001 SHALL take parameter SIMD, default 2: SIMD lanes per PE.
REQ-002 SHALL take parameter TSrcI, default 4: activation word length per lane.
REQ-003 SHALL take parameter SF, default 4: beats per dot product (MatrixW/SIMD), SF>=1.
REQ-004 SHALL take parameter NF, default 3: reuse passes per input vector (MatrixH/PE), NF>=1.
REQ-005 SHALL derive TI = TSrcI*SIMD and WA = max(1, clog2(SF*NF)).
REQ-006 SHALL have port clk, input, 1: single clock, all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have port in_v, input, 1: upstream activation word valid.
REQ-009 SHALL have port in_act, input, TI: upstream activation word.
REQ-010 SHALL have port in_rdy, output, 1: ready to accept an upstream word.
REQ-011 SHALL have port out_rdy, input, 1: downstream (PE array) may take a beat this cycle.
REQ-012 SHALL have port out_act, output, TI: activation beat to PE array.
REQ-013 SHALL have port do_mvau_stream, output, 1: out_act/wgt_addr carry a valid beat.
REQ-014 SHALL have port sf_clr, output, 1: beat is last of a dot product (sf==SF-1).
REQ-015 SHALL have port nf_clr, output, 1: beat is last of the last pass (sf==SF-1 and nf==NF-1).
REQ-016 SHALL have port wgt_addr, output, WA: weight memory address nf*SF+sf for the beat.

Function
REQ-017 SHALL hold counters sf (0..SF-1), nf (0..NF-1) and a two-state FSM: FILL, REUSE.
REQ-018 FILL: in_rdy = out_rdy; a beat issues when in_v & in_rdy; in_act written to buffer entry sf.
REQ-019 REUSE: in_rdy = 0; a beat issues when out_rdy; out_act sourced from buffer entry sf.
REQ-020 On every issued beat, sf SHALL increment, wrapping to 0 after SF-1.
REQ-021 At sf wrap: if nf==NF-1, then nf<=0 and state<=FILL; else nf<=nf+1 and state<=REUSE.
REQ-022 NF==1 SHALL keep the FSM permanently in FILL, with no buffer reads.
REQ-023 All outputs except in_rdy SHALL be registered: one-cycle latency from issue to do_mvau_stream=1.
REQ-024 No beat issued: do_mvau_stream<=0, sf_clr<=0, nf_clr<=0; out_act and wgt_addr hold last values.
REQ-025 sf_clr, nf_clr and wgt_addr SHALL be computed from the pre-increment sf/nf of the issued beat.
REQ-026 out_rdy low in any state SHALL freeze counters, FSM and buffer, with no beat lost or duplicated.
REQ-027 SF==1: every beat SHALL assert sf_clr; SF==1 and NF==1: every beat SHALL also assert nf_clr.
REQ-028 Buffer write in FILL and read in REUSE never target the same cycle; no bypass is required.

Reset
REQ-029 rst SHALL set state=FILL, sf=0, nf=0, do_mvau_stream=0, sf_clr=0, nf_clr=0, out_act=0, wgt_addr=0.
REQ-030 rst asserted mid-pass SHALL abandon the pass; the next accepted word is treated as sf=0, nf=0.
REQ-031 Buffer contents SHALL NOT be reset; REUSE never reads an entry not written in the current FILL pass.

Structure
REQ-032 TI, WA and the FSM state enum SHALL live in the shared package mvau_defn.
REQ-033 The SF x TI activation buffer SHALL be the sub-module mvau_feed_buf (1 write port, 1 asynchronous read port).
REQ-034 Control, counters and output registers SHALL stay in mvau_stream_feed; total RTL 120-400 lines.

Verification
REQ-035 SF=4, NF=3, out_rdy=1, words A0..A3 -> 12 beats: A0..A3 x3; wgt_addr 0..11; sf_clr on beats 4,8,12; nf_clr on beat 12 only; in_rdy=0 during beats 5..12.
REQ-036 SF=4, NF=1, eight words back-to-back -> eight consecutive beats; in_rdy stays 1; sf_clr on beats 4,8; nf_clr on beats 4,8; wgt_addr 0,1,2,3,0,1,2,3.
REQ-037 SF=4, NF=3, out_rdy low for 3 cycles during the REUSE pass at sf=2 -> do_mvau_stream=0 for those cycles; sequence then resumes with A2, wgt_addr=6.
REQ-038 SF=4, NF=3, rst asserted after beat 6 (REUSE pass), then new words B0..B3 -> beats restart B0, wgt_addr=0; no A-word emitted after reset.
REQ-039 SF=1, NF=2, words C0, C1 -> beats C0,C0,C1,C1; sf_clr on all beats; nf_clr on beats 2 and 4; wgt_addr 0,1,0,1.
REQ-040 in_v toggling every other cycle with out_rdy=1, SF=4, NF=1 -> beats only on accepted words, with a one-cycle gap between beats; counters advance only on accepts.
